// File: rtl/dct_transpose_pp.sv
// Ping-pong N x N transpose buffer: rows are written into one bank while the other
// bank is read out either column-wise (transpose) or row-wise (bypass).
module dct_transpose_pp #(
    parameter int DATA_W = 32,
    parameter int N      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0][DATA_W-1:0]   in_data,
    input  logic                       in_bypass,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0][DATA_W-1:0]   out_data,
    output logic                       out_last
);

    localparam int            IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [N-1:0][DATA_W-1:0] bank_q [2][N];
    logic [N-1:0][DATA_W-1:0] bank_d [2][N];

    logic [IW-1:0] wr_row_q, wr_row_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    mode_q, mode_d;

    logic in_fire;
    logic out_fire;

    // Handshake qualifiers come purely from registered state.
    assign in_ready  = ~full_q[wr_ptr_q];
    assign out_valid = full_q[rd_ptr_q];
    assign out_last  = out_valid && (rd_idx_q == LAST);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        wr_row_d = wr_row_q;
        wr_ptr_d = wr_ptr_q;
        rd_idx_d = rd_idx_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        mode_d   = mode_q;

        // A read and a write can never target the same bank in one cycle:
        // writing needs that bank empty, reading needs it full.
        if (out_fire) begin
            if (rd_idx_q == LAST) begin
                rd_idx_d         = '0;
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end

        if (in_fire) begin
            if (wr_row_q == '0) begin
                mode_d[wr_ptr_q] = in_bypass;
            end
            if (wr_row_q == LAST) begin
                wr_row_d         = '0;
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                wr_row_d = wr_row_q + 1'b1;
            end
        end
    end

    always_comb begin
        bank_d = bank_q;
        if (in_fire) begin
            bank_d[wr_ptr_q][wr_row_q] = in_data;
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int k = 0; k < N; k++) begin
                if (mode_q[rd_ptr_q]) begin
                    out_data[k] = bank_q[rd_ptr_q][rd_idx_q][k];
                end else begin
                    out_data[k] = bank_q[rd_ptr_q][k][rd_idx_q];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row_q <= '0;
            rd_idx_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= '0;
            mode_q   <= '0;
        end else begin
            wr_row_q <= wr_row_d;
            rd_idx_q <= rd_idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            mode_q   <= mode_d;
        end
    end

    // Storage is not reset; stale contents are masked because reset clears the full flags.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

endmodule

// File: tb/tb_dct_transpose_pp.sv
// Randomized bench for dct_transpose_pp against a block-level queue model.
module tb_dct_transpose_pp;

    localparam int N = 8;
    localparam int W = 32;
    typedef logic [N-1:0][W-1:0] vec_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic in_valid  = 1'b0;
    logic in_bypass = 1'b0;
    logic out_ready = 1'b0;
    vec_t in_data   = '0;
    logic in_ready;
    logic out_valid;
    logic out_last;
    vec_t out_data;

    always #5 clk = ~clk;

    dct_transpose_pp #(.DATA_W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: rows being collected, queue of pending output vectors.
    vec_t rows_m [N];
    bit   mode_m;
    int   wr_cnt = 0;
    int   held   = 0;
    int   rd_cnt = 0;
    vec_t vq [$];

    logic obs_ir, obs_ov, obs_ol;
    vec_t obs_od;
    logic exp_ir, exp_ov, exp_ol;
    vec_t exp_od;

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < N; k++) v[k] = $urandom;
        return v;
    endfunction

    function automatic vec_t pattern_row(input int r);
        vec_t v;
        for (int c = 0; c < N; c++) v[c] = W'(8 * r + c);
        return v;
    endfunction

    task automatic model_reset();
        wr_cnt = 0;
        held   = 0;
        rd_cnt = 0;
        vq.delete();
    endtask

    task automatic complete_block();
        vec_t v;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) v[k] = mode_m ? rows_m[j][k] : rows_m[k][j];
            vq.push_back(v);
        end
    endtask

    // Drive one cycle, capture DUT outputs and model predictions, advance both.
    task automatic step(input logic iv, input vec_t d, input logic byp, input logic ordy);
        bit in_f, out_f;
        in_valid  = iv;
        in_data   = d;
        in_bypass = byp;
        out_ready = ordy;
        #1;
        obs_ir = in_ready;
        obs_ov = out_valid;
        obs_ol = out_last;
        obs_od = out_data;
        exp_ir = (held < 2);
        exp_ov = (held > 0);
        exp_ol = exp_ov && (rd_cnt == N - 1);
        exp_od = exp_ov ? vq[0] : '0;
        in_f   = iv && exp_ir;
        out_f  = ordy && exp_ov;
        @(posedge clk);
        #1;
        if (out_f) begin
            void'(vq.pop_front());
            if (rd_cnt == N - 1) begin
                rd_cnt = 0;
                held--;
            end else begin
                rd_cnt++;
            end
        end
        if (in_f) begin
            if (wr_cnt == 0) mode_m = byp;
            rows_m[wr_cnt] = d;
            if (wr_cnt == N - 1) begin
                wr_cnt = 0;
                complete_block();
                held++;
            end else begin
                wr_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, out_last} !== 3'b100 || out_data !== '0) begin
            failures++;
            $display("FAIL reset ir/ov/ol=%b%b%b data=%h required 100 data=0",
                     in_ready, out_valid, out_last, out_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_transpose();
        for (int r = 0; r < N; r++) begin
            step(1'b1, pattern_row(r), 1'b0, 1'b1);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL transpose_fill r=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         r, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
        end
        for (int j = 0; j < N; j++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL transpose_model j=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         j, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (obs_ov !== 1'b1 || obs_od[k] !== W'(8 * k + j) || obs_ol !== (j == N - 1)) begin
                    failures++;
                    $display("FAIL transpose_value j=%0d k=%0d ov=%b last=%b got=%0d required=%0d",
                             j, k, obs_ov, obs_ol, obs_od[k], 8 * k + j);
                end
            end
        end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (obs_ov !== 1'b0 || obs_od !== '0) begin
            failures++;
            $display("FAIL transpose_idle ov=%b data=%h required ov=0 data=0", obs_ov, obs_od);
        end
    endtask

    task automatic test_bypass();
        for (int r = 0; r < N; r++) begin
            step(1'b1, pattern_row(r), (r == 0), 1'b1);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL bypass_fill r=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         r, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
        end
        for (int j = 0; j < N; j++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            for (int k = 0; k < N; k++) begin
                checks++;
                if (obs_ov !== 1'b1 || obs_od[k] !== W'(8 * j + k) || obs_ol !== (j == N - 1)) begin
                    failures++;
                    $display("FAIL bypass_value j=%0d k=%0d ov=%b last=%b got=%0d required=%0d",
                             j, k, obs_ov, obs_ol, obs_od[k], 8 * j + k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 2 * N; i++) begin
            step(1'b1, rand_vec(), 1'($urandom), 1'b0);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL bp_fill i=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         i, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rand_vec(), 1'b0, 1'b0);
            checks++;
            if (obs_ir !== 1'b0 || obs_ov !== 1'b1) begin
                failures++;
                $display("FAIL bp_stall i=%0d ir=%b ov=%b required ir=0 ov=1", i, obs_ir, obs_ov);
            end
        end
        for (int j = 0; j < N; j++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL bp_drain0 j=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         j, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_ir !== 1'b1 || obs_ov !== 1'b1) begin
            failures++;
            $display("FAIL bp_release ir=%b ov=%b required ir=1 ov=1", obs_ir, obs_ov);
        end
        for (int j = 0; j < N; j++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL bp_drain1 j=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         j, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  outs    = 0;
        bit  started = 1'b0;
        int  cyc     = 0;
        while (outs < 8 * N && cyc < 8 * N + 4 * N) begin
            step((cyc < 8 * N), rand_vec(), 1'($urandom), 1'b1);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL b2b_model cyc=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         cyc, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
            if (cyc < 8 * N) begin
                checks++;
                if (obs_ir !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_bubble cyc=%0d ir=%b required 1", cyc, obs_ir);
                end
            end
            if (started) begin
                checks++;
                if (obs_ov !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_out_gap cyc=%0d ov=%b required 1", cyc, obs_ov);
                end
            end
            if (obs_ov === 1'b1) begin
                started = 1'b1;
                outs++;
            end
            cyc++;
        end
        checks++;
        if (outs != 8 * N || cyc != 8 * N + N) begin
            failures++;
            $display("FAIL b2b_count outs=%0d cycles=%0d required outs=%0d cycles=%0d",
                     outs, cyc, 8 * N, 9 * N);
        end
    endtask

    task automatic test_random_stall();
        int cyc = 0;
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 7), rand_vec(), 1'($urandom), 1'($urandom));
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL stall_model i=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         i, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
        end
        while (held > 0 && cyc < 4 * N) begin
            step(1'b0, '0, 1'b0, 1'b1);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL stall_drain cyc=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         cyc, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
            cyc++;
        end
        checks++;
        if (held != 0) begin
            failures++;
            $display("FAIL stall_drain_timeout held=%0d required 0", held);
        end
    endtask

    task automatic test_mid_reset();
        // One full block parked plus five rows of the next, then reset.
        for (int i = 0; i < N + 5; i++) begin
            step(1'b1, rand_vec(), 1'($urandom), 1'b0);
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last} !== 3'b100 || out_data !== '0) begin
            failures++;
            $display("FAIL midreset ir/ov/ol=%b%b%b data=%h required 100 data=0",
                     in_ready, out_valid, out_last, out_data);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3 * N; i++) begin
            step((i < N), rand_vec(), 1'($urandom), 1'b1);
            checks++;
            if ({obs_ir, obs_ov, obs_ol} !== {exp_ir, exp_ov, exp_ol} || obs_od !== exp_od) begin
                failures++;
                $display("FAIL midreset_block i=%0d ir/ov/ol=%b%b%b data=%h required %b%b%b data=%h",
                         i, obs_ir, obs_ov, obs_ol, obs_od, exp_ir, exp_ov, exp_ol, exp_od);
            end
        end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_random_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dct_transpose_pp.md
DCT_TRANSPOSE_PP -- requirements
Module: dct_transpose_pp

Interface
REQ-001 Parameter DATA_W, default 32, width of one coefficient word.
REQ-002 Parameter N, default 8, block dimension (N rows x N columns per block); legal values 2..16.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  input row word present.
REQ-006 Port in_ready  output  1  block accepts an input row this cycle.
REQ-007 Port in_data  input  N x DATA_W  one block row, element k = column k.
REQ-008 Port in_bypass  input  1  per-block mode: 1 = output rows unchanged, 0 = output transposed; sampled with row 0 of each block.
REQ-009 Port out_valid  output  1  output vector present.
REQ-010 Port out_ready  input  1  downstream accepts output vector.
REQ-011 Port out_data  output  N x DATA_W  one output vector, element k = row k (transpose) or column k (bypass).
REQ-012 Port out_last  output  1  marks final vector (index N-1) of a block.

Function
REQ-013 The block SHALL hold two N x N banks (ping-pong), a write-bank pointer, read-bank pointer, per-bank full flag and per-bank stored mode bit.
REQ-014 An input handshake (in_valid and in_ready high at clk edge) SHALL write in_data into row wr_row of the write bank and increment wr_row.
REQ-015 On the handshake with wr_row = N-1, the block SHALL set the write bank's full flag, wrap wr_row to 0 and toggle the write-bank pointer.
REQ-016 in_bada sampled on the row-0 handshake SHALL be stored as that bank's mode; in_bypass on rows 1..N-1 SHALL be ignored.
REQ-017 in_ready SHALL equal NOT full[write bank] and SHALL depend only on registered state (no combinational path from out_ready or in_valid).
REQ-018 out_valid SHALL equal full[read bank]; first out_valid of a block SHALL assert in the cycle after the row N-1 handshake (latency 1 cycle).
REQ-019 With read index rd_idx, out_data element k SHALL be bank[k][rd_idx] when stored mode = 0 and bank[rd_idx][k] when mode = 1.
REQ-020 out_last SHALL be high iff out_valid high and rd_idx = N-1.
REQ-021 out_data SHALL be all-zero whenever out_valid is low; out_data and out_last SHALL stay stable while out_valid high and out_ready low.
REQ-022 An output handshake SHALL increment rd_idx; on the handshake with rd_idx = N-1 the block SHALL clear the read bank's full flag, wrap rd_idx to 0 and toggle the read-bank pointer.
REQ-023 When both banks are full, in_ready SHALL be low; a bank freed by an output handshake SHALL raise in_ready in the next cycle.
REQ-024 Simultaneous input and output handshakes SHALL both take effect in the same cycle, including row N-1 write coinciding with final read of the other bank.
REQ-025 Sustained in_valid = out_ready = 1 SHALL give one row in and one vector out per cycle with no bubbles after the first block.
REQ-026 Bank contents SHALL only change on input handshakes to the write bank; a full bank SHALL never be overwritten.

Reset
REQ-027 While rst_n low: wr_row, rd_idx, both pointers, both full flags and mode bits = 0; in_ready = 1; out_valid = 0; out_last = 0; out_data = 0.
REQ-028 Reset asserted mid-block SHALL discard all partial and full blocks; bank contents need not be cleared but SHALL never appear on out_data before being rewritten.

Verification
REQ-029 N=8, DATA_W=32, in_bypass=0, rows with element(r,c)=8r+c, out_ready=1 -> out_valid one cycle after row 7; vector j element k = 8k+j; out_last on j=7 only.
REQ-030 Same data with in_bypass=1 on row 0 and 0 on rows 1..7 -> vector j element k = 8j+k (rows unchanged).
REQ-031 out_ready=0, feed 16 rows back-to-back -> in_ready drops after row 15 handshake, stays low; releasing out_ready for 8 handshakes -> in_ready high next cycle; data of block 0 then block 1 in order.
REQ-032 Continuous in_valid=out_ready=1 for 64 rows -> 64 output vectors, no gap after first, all transposed correctly, out_last every 8th.
REQ-033 Random out_ready stall mid-block -> out_data and out_last held constant during every stall cycle.
REQ-034 Assert rst_n low after 5 rows of a block -> out_valid=0, in_ready=1, out_data=0 immediately; next 8 rows produce one correct block with no stale data.
